lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised pseudo-random sequence generator; next generation of the fixed 16-bit Galois LFSR.
- Adds selectable width and polynomial, Galois/Fibonacci mode, enable, and seed load.
- Adds multi-step advance per clock, zero-state lock-up protection, and period-return detection.
- Feeds PRBS test-pattern, scrambler and BIST stimulus paths.

Parameters:
- WIDTH, 16, register width; legal 3..32.
- POLY, 16'hB400, Galois tap mask: bit k set = term x^(k+1). Default is x^16+x^14+x^13+x^11+1.
- STEPS, 1, LFSR shifts applied per enabled cycle; legal 1..WIDTH.
- RESET_SEED, 16'hACE1, state value at reset and substitute for zero seeds; must be nonzero.

Ports:
- clk  input  1  clock; all flops on rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 clears immediately, release synchronous to clk.
- load  input  1  capture seed this cycle.
- seed  input  WIDTH  seed value sampled when load=1.
- en  input  1  advance STEPS shifts this cycle.
- mode  input  1  0 = Galois, 1 = Fibonacci.
- state  output  WIDTH  current LFSR register.
- step_cnt  output  WIDTH  single shifts since last load/reset/wrap.
- wrap  output  1  one-cycle pulse: state returned to reference seed.
- lockup  output  1  one-cycle pulse: all-zero condition detected and corrected.

Behaviour:
- Reset (rst=0): state=RESET_SEED, reference seed register=RESET_SEED, step_cnt=0, wrap=0, lockup=0.
- Galois single shift: next = (state>>1) ^ (state[0] ? POLY : 0).
- Fibonacci single shift:
  - FMASK = bit-reverse of POLY; fb = XOR-reduce(state & FMASK).
  - next = (state>>1) | (fb<<(WIDTH-1)).
  - Both modes are maximal-length for a primitive POLY.
- Per-cycle update:
  - STEPS shifts are chained combinationally and registered once; latency 1 cycle from en to new state.
- Priority: load > en > hold.
- load=1:
  - If seed nonzero: state=seed, reference seed=seed, step_cnt=0.
  - If seed==0: state=RESET_SEED, reference seed=RESET_SEED, step_cnt=0, lockup=1 next cycle.
  - en is ignored in a load cycle.
- en=1, load=0: state advances STEPS shifts; step_cnt += STEPS (modulo 2^WIDTH).
- Wrap detection:
  - When the registered new state equals the reference seed: wrap=1 for that cycle and step_cnt=0 instead of incrementing.
  - Only the post-step state is compared. With STEPS>1, an intermediate match is not detected.
- Zero-state guard:
  - If the computed next state is all-zero (reachable only via non-primitive POLY), load RESET_SEED instead; lockup=1; step_cnt=0.
- mode may change any cycle:
  - Takes effect on the next enabled step.
  - Reference seed and step_cnt are not reset.
  - wrap timing after a mid-sequence mode switch is whatever the compare yields; no guarantee.
- en=0, load=0: all registers hold; wrap=0, lockup=0.
- wrap and lockup are registered outputs, low on any cycle without the triggering event.
- Reset asserted mid-sequence: immediate return to reset values regardless of clk.

Test Plan:
1. Reset: rst=0 → state=16'hACE1, step_cnt=0, wrap=0, lockup=0; release, en=0 for 5 cycles → state holds 16'hACE1.
2. Galois stepping: from 16'hACE1, mode=0, en=1 for 3 cycles → state 16'hE270, 16'h7138, 16'h389C; step_cnt 1, 2, 3.
3. Fibonacci stepping: load 16'hACE1, mode=1, en=1 for 1 cycle → state=16'h5670, step_cnt=1.
4. Full period: Galois, seed 16'hACE1, en=1 continuously → wrap pulses exactly on cycle 65535, state=16'hACE1, step_cnt=0; no other wrap pulse.
5. Zero seed and load priority: load=1 with seed=0 and en=1 in the same cycle → state=16'hACE1, lockup=1 next cycle, step_cnt=0, no advance.
6. Multi-step and reset: STEPS=2 instance, seed 16'hACE1, en=1 for 1 cycle → state=16'h7138, step_cnt=2; then assert rst mid-run → state=16'hACE1 asynchronously.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Galois/Fibonacci LFSR with seed load, multi-step, lock-up guard and wrap detect
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   load     capture seed this cycle (wins over en)
//   seed     seed value; a zero seed is replaced by RESET_SEED
//   en       advance STEPS single shifts this cycle
//   mode     0 = Galois, 1 = Fibonacci
//   state    current LFSR register
//   step_cnt single shifts since last load/reset/wrap
//   wrap     one-cycle pulse: state returned to the reference seed
//   lockup   one-cycle pulse: all-zero state detected and replaced

module lfsr_gen #(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'hB400,
    parameter int              STEPS      = 1,
    parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] step_cnt,
    output logic             wrap,
    output logic             lockup
);

    // Fibonacci tap mask is the Galois mask mirrored end to end.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] FMASK = bit_rev(POLY);

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s, input logic m);
        logic [WIDTH-1:0] n;
        logic             fb;
        if (m) begin
            fb = ^(s & FMASK);
            n  = (s >> 1) | ({{(WIDTH-1){1'b0}}, fb} << (WIDTH-1));
        end else begin
            n  = (s >> 1) ^ (s[0] ? POLY : '0);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] ref_seed;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] ref_d;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_d;
    logic             lockup_d;

    // All STEPS shifts are chained in one combinational cone and
    // registered once, so only the post-step state is ever compared.
    always_comb begin
        stepped = state;
        for (int i = 0; i < STEPS; i++) begin
            stepped = shift1(stepped, mode);
        end
    end

    always_comb begin
        state_d  = state;
        ref_d    = ref_seed;
        cnt_d    = step_cnt;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            cnt_d = '0;
            if (seed == '0) begin
                state_d  = RESET_SEED;
                ref_d    = RESET_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = seed;
                ref_d   = seed;
            end
        end else if (en) begin
            if (stepped == '0) begin
                // Only reachable with a non-primitive POLY.
                state_d  = RESET_SEED;
                cnt_d    = '0;
                lockup_d = 1'b1;
            end else if (stepped == ref_seed) begin
                state_d = stepped;
                cnt_d   = '0;
                wrap_d  = 1'b1;
            end else begin
                state_d = stepped;
                cnt_d   = step_cnt + WIDTH'(STEPS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_SEED;
            ref_seed <= RESET_SEED;
            step_cnt <= '0;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end else begin
            state    <= state_d;
            ref_seed <= ref_d;
            step_cnt <= cnt_d;
            wrap     <= wrap_d;
            lockup   <= lockup_d;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen (STEPS=1 and STEPS=2 instances)

module tb_lfsr_gen;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] seed;
    logic        en;
    logic        mode;

    logic [15:0] state1, cnt1, state2, cnt2;
    logic        wrap1, lockup1, wrap2, lockup2;

    int compared = 0;
    int mismatched = 0;

    lfsr_gen #(.WIDTH(16), .POLY(16'hB400), .STEPS(1), .RESET_SEED(16'hACE1)) u1 (
        .clk(clk), .rst(rst), .load(load), .seed(seed), .en(en), .mode(mode),
        .state(state1), .step_cnt(cnt1), .wrap(wrap1), .lockup(lockup1)
    );

    lfsr_gen #(.WIDTH(16), .POLY(16'hB400), .STEPS(2), .RESET_SEED(16'hACE1)) u2 (
        .clk(clk), .rst(rst), .load(load), .seed(seed), .en(en), .mode(mode),
        .state(state2), .step_cnt(cnt2), .wrap(wrap2), .lockup(lockup2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          wraps;
    int          wrap_cycle;
    logic [15:0] wrap_state;
    logic [15:0] wrap_cnt;
    logic [15:0] pre_cnt;
    logic        reset_ok;

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        seed = 16'h0000;
        en   = 1'b0;
        mode = 1'b0;

        // 1. reset values, then hold with en=0
        repeat (3) @(negedge clk);
        check("rst_state", state1, 16'hACE1);
        check("rst_cnt", cnt1, 16'h0);
        check("rst_wrap", wrap1, 1'b0);
        check("rst_lockup", lockup1, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_state", state1, 16'hACE1);
        check("hold_cnt", cnt1, 16'h0);

        // 2. Galois stepping
        en = 1'b1;
        @(negedge clk);
        check("gal1_state", state1, 16'hE270);
        check("gal1_cnt", cnt1, 16'd1);
        @(negedge clk);
        check("gal2_state", state1, 16'h7138);
        check("gal2_cnt", cnt1, 16'd2);
        @(negedge clk);
        check("gal3_state", state1, 16'h389C);
        check("gal3_cnt", cnt1, 16'd3);
        en = 1'b0;
        @(negedge clk);
        check("gal_hold", state1, 16'h389C);

        // 3. Fibonacci stepping
        load = 1'b1;
        seed = 16'hACE1;
        mode = 1'b1;
        @(negedge clk);
        check("fib_load_state", state1, 16'hACE1);
        check("fib_load_cnt", cnt1, 16'h0);
        load = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        check("fib1_state", state1, 16'h5670);
        check("fib1_cnt", cnt1, 16'd1);
        en   = 1'b0;
        mode = 1'b0;

        // 4. full Galois period
        load = 1'b1;
        seed = 16'hACE1;
        @(negedge clk);
        load       = 1'b0;
        en         = 1'b1;
        wraps      = 0;
        wrap_cycle = -1;
        wrap_state = 16'h0;
        wrap_cnt   = 16'hFFFF;
        pre_cnt    = 16'h0;
        for (int i = 1; i <= 65536; i++) begin
            @(negedge clk);
            if (i == 65534) pre_cnt = cnt1;
            if (wrap1) begin
                wraps++;
                if (wrap_cycle < 0) begin
                    wrap_cycle = i;
                    wrap_state = state1;
                    wrap_cnt   = cnt1;
                end
            end
        end
        en = 1'b0;
        check("period_wrap_count", wraps, 32'd1);
        check("period_wrap_cycle", wrap_cycle, 32'd65535);
        check("period_wrap_state", wrap_state, 16'hACE1);
        check("period_wrap_cnt", wrap_cnt, 16'h0);
        check("period_pre_cnt", pre_cnt, 16'd65534);
        @(negedge clk);
        check("period_post_cnt", cnt1, 16'd1);
        check("period_wrap_low", wrap1, 1'b0);

        // 5. zero seed with en in the same cycle
        en   = 1'b1;
        @(negedge clk);
        load = 1'b1;
        seed = 16'h0000;
        @(negedge clk);
        check("zero_state", state1, 16'hACE1);
        check("zero_lockup", lockup1, 1'b1);
        check("zero_cnt", cnt1, 16'h0);
        load = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        check("zero_lockup_low", lockup1, 1'b0);
        check("zero_no_adv", state1, 16'hACE1);

        // 6. STEPS=2 and asynchronous reset mid-run
        load = 1'b1;
        seed = 16'hACE1;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        check("multi_state", state2, 16'h7138);
        check("multi_cnt", cnt2, 16'd2);
        @(negedge clk);
        check("multi_state2", state2, 16'h389C >> 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        reset_ok = (state2 == 16'hACE1) && (cnt2 == 16'h0);
        check("async_rst_state2", state2, 16'hACE1);
        check("async_rst_cnt2", cnt2, 16'h0);
        check("async_rst_state1", state1, 16'hACE1);
        check("async_rst_both", reset_ok, 1'b1);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
